// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback, M-unit result handshake,
// register file write port and hazard-unit outputs.
interface wb_arbiter_if;
    logic        PIPE_WE;
    logic [4:0]  PIPE_ADDR;
    logic [31:0] PIPE_DATA;
    logic        MUL_VALID;
    logic [4:0]  MUL_ADDR;
    logic [31:0] MUL_DATA;
    logic        MUL_READY;
    logic        PIPE_HOLD;
    logic        WRITE_ENABLE;
    logic [4:0]  WB_ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] BUSY_MASK;

    modport master (
        output PIPE_WE, PIPE_ADDR, PIPE_DATA, MUL_VALID, MUL_ADDR, MUL_DATA,
        input  MUL_READY, PIPE_HOLD, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA, BUSY_MASK
    );

    modport slave (
        input  PIPE_WE, PIPE_ADDR, PIPE_DATA, MUL_VALID, MUL_ADDR, MUL_DATA,
        output MUL_READY, PIPE_HOLD, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA, BUSY_MASK
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register file write-port arbiter: pipeline writebacks win the slot, M-unit
// results wait in a 2-entry FIFO, stale entries are cancelled, starvation forces a hold.
module wb_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    wb_arbiter_if.slave  bus
);
    localparam logic [1:0] DEPTH = 2'd2;

    logic [1:0]  ent_valid_q, ent_valid_d;
    logic [4:0]  ent_addr_q [2];
    logic [31:0] ent_data_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [2:0]  starv_q, starv_d;
    logic        hold_q, hold_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic        mul_ready;
    logic        push;
    logic        pop;
    logic        pipe_win;
    logic        head_present;
    logic        head_valid;
    logic [31:0] busy_mask;

    // A pop in the same cycle does not free a slot: readiness looks at count only.
    assign mul_ready    = !RESET && (count_q != DEPTH);
    assign push         = bus.MUL_VALID && mul_ready && (bus.MUL_ADDR != 5'd0);
    assign pipe_win     = !hold_q && bus.PIPE_WE && (bus.PIPE_ADDR != 5'd0);
    assign head_present = (count_q != 2'd0);
    assign head_valid   = head_present && ent_valid_q[rd_ptr_q];
    assign pop          = !pipe_win && head_present;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        ent_valid_d = ent_valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        starv_d     = starv_q;
        hold_d      = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;

        if (pipe_win) begin
            we_d   = 1'b1;
            addr_d = bus.PIPE_ADDR;
            data_d = bus.PIPE_DATA;
            // Older queued results to the same register would overwrite newer data.
            for (int i = 0; i < 2; i++) begin
                if (ent_valid_q[i] && (ent_addr_q[i] == bus.PIPE_ADDR)) begin
                    ent_valid_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            if (head_valid) begin
                we_d   = 1'b1;
                addr_d = ent_addr_q[rd_ptr_q];
                data_d = ent_data_q[rd_ptr_q];
            end
            ent_valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = ~rd_ptr_q;
        end

        // Applied after the cancel so a same-cycle push to the same register survives.
        if (push) begin
            ent_valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = ~wr_ptr_q;
        end

        count_d = count_q + 2'(push) - 2'(pop);

        if (pop) begin
            starv_d = 3'd0;
        end else if (pipe_win && head_valid) begin
            if (starv_q == 3'd3) begin
                starv_d = 3'd0;
                hold_d  = 1'b1;
            end else begin
                starv_d = starv_q + 3'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ent_valid_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            starv_q     <= 3'd0;
            hold_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= 32'd0;
        end else begin
            ent_valid_q <= ent_valid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starv_q     <= starv_d;
            hold_q      <= hold_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone decide whether an entry exists.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= bus.MUL_ADDR;
            ent_data_q[wr_ptr_q] <= bus.MUL_DATA;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid_q[i]) begin
                busy_mask[ent_addr_q[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    assign bus.MUL_READY    = mul_ready;
    assign bus.PIPE_HOLD    = hold_q;
    assign bus.WRITE_ENABLE = we_q;
    assign bus.WB_ADDRESS   = addr_q;
    assign bus.WRITE_DATA   = data_q;
    assign bus.BUSY_MASK    = busy_mask;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-level model is compared every cycle,
// and literal expectations pin the documented scenarios.
module tb_wb_arbiter;
    typedef struct packed {
        bit        v;
        bit [4:0]  a;
        bit [31:0] d;
    } ent_t;

    logic CLK = 1'b0;
    logic RESET;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial forever #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the registered outputs must be after the latest edge.
    ent_t        mq[$];
    bit [2:0]    m_starv;
    bit          m_hold;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          live = 1'b0;

    logic [31:0] rf [32];
    int          wlog[$];
    int          exp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(wlog.size()), 32'(exp_log.size()));
        if (wlog.size() == exp_log.size()) begin
            for (int i = 0; i < exp_log.size(); i++) begin
                check(name, 32'(wlog[i]), 32'(exp_log[i]));
            end
        end
    endtask

    task automatic model_step();
        bit pw;
        bit headv;
        bit ready;
        bit popped;
        bit nhold;
        if (RESET) begin
            mq.delete();
            m_starv = 3'd0;
            m_hold  = 1'b0;
            m_we    = 1'b0;
            m_addr  = 5'd0;
            m_data  = 32'd0;
            live    = 1'b1;
            return;
        end
        ready  = (mq.size() < 2);
        pw     = !m_hold && bus.PIPE_WE && (bus.PIPE_ADDR != 5'd0);
        headv  = (mq.size() > 0) && mq[0].v;
        popped = 1'b0;
        m_we   = 1'b0;
        if (pw) begin
            m_we   = 1'b1;
            m_addr = bus.PIPE_ADDR;
            m_data = bus.PIPE_DATA;
            foreach (mq[i]) if (mq[i].a == bus.PIPE_ADDR) mq[i].v = 1'b0;
        end else if (mq.size() > 0) begin
            if (mq[0].v) begin
                m_we   = 1'b1;
                m_addr = mq[0].a;
                m_data = mq[0].d;
            end
            void'(mq.pop_front());
            popped = 1'b1;
        end
        if (bus.MUL_VALID && ready && (bus.MUL_ADDR != 5'd0))
            mq.push_back('{v: 1'b1, a: bus.MUL_ADDR, d: bus.MUL_DATA});
        nhold = 1'b0;
        if (popped) begin
            m_starv = 3'd0;
        end else if (pw && headv) begin
            if (m_starv == 3'd3) begin
                m_starv = 3'd0;
                nhold   = 1'b1;
            end else begin
                m_starv = m_starv + 3'd1;
            end
        end
        m_hold = nhold;
    endtask

    // Inputs stay put until #1 after the edge, so the model sees what the DUT sampled.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.PIPE_WE   = 1'b0;
        bus.PIPE_ADDR = 5'd0;
        bus.PIPE_DATA = 32'd0;
        bus.MUL_VALID = 1'b0;
        bus.MUL_ADDR  = 5'd0;
        bus.MUL_DATA  = 32'd0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        bus.PIPE_WE   = 1'b1;
        bus.PIPE_ADDR = a;
        bus.PIPE_DATA = d;
    endtask

    task automatic mul(input logic [4:0] a, input logic [31:0] d);
        bus.MUL_VALID = 1'b1;
        bus.MUL_ADDR  = a;
        bus.MUL_DATA  = d;
    endtask

    always @(posedge CLK) begin
        if (bus.WRITE_ENABLE === 1'b1) rf[bus.WB_ADDRESS] <= bus.WRITE_DATA;
    end

    always @(negedge CLK) begin : compare
        logic [31:0] eb;
        if (live) begin
            eb = '0;
            foreach (mq[i]) if (mq[i].v) eb[mq[i].a] = 1'b1;
            eb[0] = 1'b0;
            check("m_write_enable", 32'(bus.WRITE_ENABLE), 32'(m_we));
            check("m_wb_address",   32'(bus.WB_ADDRESS),   32'(m_addr));
            check("m_write_data",   bus.WRITE_DATA,        m_data);
            check("m_pipe_hold",    32'(bus.PIPE_HOLD),    32'(m_hold));
            check("m_busy_mask",    bus.BUSY_MASK,         eb);
            check("m_mul_ready",    32'(bus.MUL_READY),    32'(!RESET && (mq.size() < 2)));
            if (bus.WRITE_ENABLE === 1'b1) wlog.push_back(int'(bus.WB_ADDRESS));
        end
    end

    initial begin
        RESET = 1'b1;
        idle();
        cyc();
        cyc();
        check("rst_mul_ready", 32'(bus.MUL_READY), 32'd0);
        check("rst_we",        32'(bus.WRITE_ENABLE), 32'd0);
        check("rst_addr",      32'(bus.WB_ADDRESS), 32'd0);
        check("rst_data",      bus.WRITE_DATA, 32'd0);
        check("rst_busy",      bus.BUSY_MASK, 32'd0);
        check("rst_hold",      32'(bus.PIPE_HOLD), 32'd0);
        RESET = 1'b0;
        cyc();

        // Pipeline write x2 = 0x0A
        pipe(5'd2, 32'h0000_000A);
        cyc();
        idle();
        check("p_we",   32'(bus.WRITE_ENABLE), 32'd1);
        check("p_addr", 32'(bus.WB_ADDRESS), 32'd2);
        check("p_data", bus.WRITE_DATA, 32'h0000_000A);
        cyc();
        check("p_rf_x2", rf[2], 32'h0000_000A);

        // M result x5 = 0x0B, pipeline idle
        mul(5'd5, 32'h0000_000B);
        cyc();
        idle();
        check("m_busy_set", bus.BUSY_MASK, 32'h0000_0020);
        check("m_we_wait",  32'(bus.WRITE_ENABLE), 32'd0);
        cyc();
        check("m_we",       32'(bus.WRITE_ENABLE), 32'd1);
        check("m_addr",     32'(bus.WB_ADDRESS), 32'd5);
        check("m_data",     bus.WRITE_DATA, 32'h0000_000B);
        check("m_busy_clr", bus.BUSY_MASK, 32'd0);
        cyc();

        // Conflict: x3 from the pipeline, then x6 and x7 from the FIFO
        wlog.delete();
        pipe(5'd3, 32'h1);
        mul(5'd6, 32'hC);
        cyc();
        idle();
        check("c_busy", bus.BUSY_MASK, 32'h0000_0040);
        mul(5'd7, 32'hD);
        cyc();
        idle();
        cyc();
        cyc();
        exp_log = '{3, 6, 7};
        check_log("c_order");

        // Fill the FIFO behind pipeline writes; MUL_READY drops at count 2
        wlog.delete();
        pipe(5'd10, 32'h10);
        mul(5'd12, 32'h12);
        cyc();
        pipe(5'd11, 32'h11);
        mul(5'd13, 32'h13);
        cyc();
        idle();
        mul(5'd14, 32'h14);
        check("f_ready_full", 32'(bus.MUL_READY), 32'd0);
        check("f_busy_full",  bus.BUSY_MASK, 32'h0000_3000);
        cyc();
        check("f_ready_free", 32'(bus.MUL_READY), 32'd1);
        cyc();
        idle();
        cyc();
        cyc();
        exp_log = '{10, 11, 12, 13, 14};
        check_log("f_order");

        // Cancel: queued x8 overtaken by a pipeline write to x8
        wlog.delete();
        mul(5'd8, 32'h11);
        cyc();
        idle();
        check("x_busy_set", bus.BUSY_MASK, 32'h0000_0100);
        pipe(5'd8, 32'h22);
        cyc();
        idle();
        check("x_busy_clr", bus.BUSY_MASK, 32'd0);
        check("x_we",       32'(bus.WRITE_ENABLE), 32'd1);
        check("x_data",     bus.WRITE_DATA, 32'h22);
        cyc();
        check("x_no_write", 32'(bus.WRITE_ENABLE), 32'd0);
        check("x_hold_data", bus.WRITE_DATA, 32'h22);
        cyc();
        check("x_rf_x8", rf[8], 32'h22);
        exp_log = '{8};
        check_log("x_order");

        // Starvation: four bypass cycles force one hold cycle that drains x9
        wlog.delete();
        mul(5'd9, 32'h33);
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            pipe(5'(20 + k), 32'(k));
            cyc();
            check("s_hold", 32'(bus.PIPE_HOLD), (k == 3) ? 32'd1 : 32'd0);
        end
        check("s_busy", bus.BUSY_MASK, 32'h0000_0200);
        pipe(5'd24, 32'hEE);
        cyc();
        idle();
        check("s_we",        32'(bus.WRITE_ENABLE), 32'd1);
        check("s_addr",      32'(bus.WB_ADDRESS), 32'd9);
        check("s_data",      bus.WRITE_DATA, 32'h33);
        check("s_hold_done", 32'(bus.PIPE_HOLD), 32'd0);
        cyc();
        exp_log = '{20, 21, 22, 23, 9};
        check_log("s_order");

        // x0 targets: no write, no busy bit; a pipe x0 write leaves the slot free
        wlog.delete();
        mul(5'd0, 32'h55);
        pipe(5'd0, 32'h66);
        cyc();
        idle();
        check("z_we",    32'(bus.WRITE_ENABLE), 32'd0);
        check("z_busy",  bus.BUSY_MASK, 32'd0);
        check("z_ready", 32'(bus.MUL_READY), 32'd1);
        mul(5'd15, 32'h15);
        cyc();
        idle();
        pipe(5'd0, 32'h77);
        cyc();
        idle();
        check("z_drain_we",   32'(bus.WRITE_ENABLE), 32'd1);
        check("z_drain_addr", 32'(bus.WB_ADDRESS), 32'd15);
        check("z_drain_data", bus.WRITE_DATA, 32'h15);
        cyc();
        exp_log = '{15};
        check_log("z_order");

        // Reset with a full FIFO discards both queued results
        pipe(5'd16, 32'h1);
        mul(5'd17, 32'h17);
        cyc();
        pipe(5'd16, 32'h2);
        mul(5'd18, 32'h18);
        cyc();
        idle();
        check("r_busy_full", bus.BUSY_MASK, 32'h0006_0000);
        RESET = 1'b1;
        cyc();
        check("r_we",   32'(bus.WRITE_ENABLE), 32'd0);
        check("r_addr", 32'(bus.WB_ADDRESS), 32'd0);
        check("r_data", bus.WRITE_DATA, 32'd0);
        check("r_busy", bus.BUSY_MASK, 32'd0);
        check("r_hold", 32'(bus.PIPE_HOLD), 32'd0);
        RESET = 1'b0;
        wlog.delete();
        repeat (4) cyc();
        exp_log.delete();
        check_log("r_no_write");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
